// File: rtl/pim_pkg.sv
// -----------------------------------------------------------------------------
// pim_pkg
// Shared definitions for the PIM frame sequencer slice: lane count, default
// sample/result widths and the sequencer state encoding.
// -----------------------------------------------------------------------------
package pim_pkg;

    localparam int PIM_LANES  = 4;
    localparam int PIM_DATA_W = 6;
    localparam int PIM_OUT_W  = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        OUT   = 2'd3
    } pim_seq_state_t;

endpackage

// File: rtl/pim_window_buf.sv
// -----------------------------------------------------------------------------
// pim_window_buf
// Four-lane sample register file. Samples are written one at a time into the
// lane selected by an internal fill index; the whole window plus index can also
// be bulk-loaded in one cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_wr, i_data      write i_data into lane o_idx and advance the index
//   i_clr_idx         return the index to 0 (lane contents kept)
//   i_load            bulk load i_load_lanes / i_load_idx (wins over i_wr)
//   o_lanes           lane 0 in the least significant DATA_W bits
//   o_idx, o_full     next lane to fill, all four lanes written
// -----------------------------------------------------------------------------
module pim_window_buf
    import pim_pkg::*;
#(
    parameter int DATA_W = PIM_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wr,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_clr_idx,
    input  logic                        i_load,
    input  logic [PIM_LANES*DATA_W-1:0] i_load_lanes,
    input  logic [1:0]                  i_load_idx,
    output logic [PIM_LANES*DATA_W-1:0] o_lanes,
    output logic [1:0]                  o_idx,
    output logic                        o_full
);

    logic [PIM_LANES*DATA_W-1:0] r_lanes;
    // Fill count: 0..3 is the next lane, 4 means the window is full.
    logic [2:0]                  r_cnt;
    logic                        w_wr;

    // A full window ignores further writes so lane 0 is never clobbered.
    assign w_wr = i_wr && !r_cnt[2];

    // Lane storage: bulk load has priority over a single-sample write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lanes <= {(PIM_LANES*DATA_W){1'b0}};
        end else if (i_load) begin
            r_lanes <= i_load_lanes;
        end else begin
            for (int i = 0; i < PIM_LANES; i++) begin
                if (w_wr && (r_cnt[1:0] == i[1:0])) begin
                    r_lanes[i*DATA_W +: DATA_W] <= i_data;
                end else begin
                    r_lanes[i*DATA_W +: DATA_W] <= r_lanes[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Fill index: load, then clear, then advance on a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= {1'b0, i_load_idx};
        end else if (i_clr_idx) begin
            r_cnt <= 3'd0;
        end else if (w_wr) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_lanes = r_lanes;
    assign o_idx   = r_cnt[1:0];
    assign o_full  = r_cnt[2];

endmodule

// File: rtl/pim_frame_sequencer.sv
// -----------------------------------------------------------------------------
// pim_frame_sequencer
// Packs signed samples into 4-lane windows, strobes the PIM array (one write
// cycle, RD_LAT read cycles), captures the array result and returns it on a
// valid/ready stream.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_valid/s_ready/s_data     sample input stream
//   pim_data_in0..3            active window lanes to the array (registered)
//   pim_write, pim_read        array strobes (registered, never both high)
//   pim_data_out               array result
//   m_valid/m_ready/m_data     result output stream
//   frames_done                results accepted downstream, wraps at 16 bits
//
// Build option:
//   PIM_PREFETCH_EN  adds a shadow window that keeps accepting samples while
//                    the active window is in WRITE/READ/OUT.
// -----------------------------------------------------------------------------
module pim_frame_sequencer
    import pim_pkg::*;
#(
    parameter int DATA_W = PIM_DATA_W,
    parameter int OUT_W  = PIM_OUT_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] pim_data_in0,
    output logic [DATA_W-1:0] pim_data_in1,
    output logic [DATA_W-1:0] pim_data_in2,
    output logic [DATA_W-1:0] pim_data_in3,
    output logic              pim_write,
    output logic              pim_read,
    input  logic [OUT_W-1:0]  pim_data_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic [15:0]       frames_done
);

    localparam int         WIN_W   = PIM_LANES * DATA_W;
    localparam logic [2:0] RD_INIT = 3'(RD_LAT - 1);

    pim_seq_state_t     r_state;
    pim_seq_state_t     w_state_nxt;
    pim_seq_state_t     w_out_nxt;
    logic [2:0]         r_rd_cnt;
    logic               r_s_ready;
    logic               r_pim_write;
    logic               r_pim_read;
    logic               r_m_valid;
    logic [OUT_W-1:0]   r_m_data;
    logic [15:0]        r_frames_done;

    logic               w_s_acc;
    logic               w_fill_acc;
    logic               w_last_lane;
    logic               w_m_hs;
    logic               w_s_ready_nxt;
    logic               w_busy_ready_nxt;

    logic [WIN_W-1:0]   w_act_lanes;
    logic [1:0]         w_act_idx;
    logic               w_act_full;
    logic               w_act_load;
    logic [WIN_W-1:0]   w_act_load_lanes;
    logic [1:0]         w_act_load_idx;

    assign w_s_acc     = s_valid && r_s_ready;
    assign w_fill_acc  = w_s_acc && (r_state == FILL) && !w_act_full;
    assign w_last_lane = w_fill_acc && (w_act_idx == 2'd3);
    assign w_m_hs      = r_m_valid && m_ready;

    // Active window; its index wraps to 0 on the lane-3 accept.
    pim_window_buf #(.DATA_W(DATA_W)) u_act_buf (
        .clk          (clk),
        .rst          (rst),
        .i_wr         (w_fill_acc),
        .i_data       (s_data),
        .i_clr_idx    (w_last_lane),
        .i_load       (w_act_load),
        .i_load_lanes (w_act_load_lanes),
        .i_load_idx   (w_act_load_idx),
        .o_lanes      (w_act_lanes),
        .o_idx        (w_act_idx),
        .o_full       (w_act_full)
    );

`ifdef PIM_PREFETCH_EN
    logic               w_shd_acc;
    logic [WIN_W-1:0]   w_shd_lanes;
    logic [1:0]         w_shd_idx;
    logic               w_shd_full;
    logic [WIN_W-1:0]   w_merge_lanes;
    logic [2:0]         w_merge_cnt;
    logic [2:0]         w_shd_cnt_nxt;

    assign w_shd_acc = w_s_acc && (r_state != FILL);

    pim_window_buf #(.DATA_W(DATA_W)) u_shd_buf (
        .clk          (clk),
        .rst          (rst),
        .i_wr         (w_shd_acc),
        .i_data       (s_data),
        .i_clr_idx    (w_m_hs),
        .i_load       (1'b0),
        .i_load_lanes ({WIN_W{1'b0}}),
        .i_load_idx   (2'd0),
        .o_lanes      (w_shd_lanes),
        .o_idx        (w_shd_idx),
        .o_full       (w_shd_full)
    );

    // Shadow window as it will be after this edge, so a sample accepted on
    // the same cycle as the output handshake is not lost in the hand-over.
    always_comb begin
        w_merge_lanes = w_shd_lanes;
        for (int i = 0; i < PIM_LANES; i++) begin
            w_merge_lanes[i*DATA_W +: DATA_W] =
                (w_shd_acc && (w_shd_idx == i[1:0])) ? s_data
                                                     : w_shd_lanes[i*DATA_W +: DATA_W];
        end
    end

    assign w_merge_cnt      = {w_shd_full, w_shd_idx} + {2'b00, w_shd_acc};
    assign w_act_load       = w_m_hs;
    assign w_act_load_lanes = w_merge_lanes;
    assign w_act_load_idx   = w_merge_cnt[2] ? 2'd0 : w_merge_cnt[1:0];
    assign w_out_nxt        = w_merge_cnt[2] ? WRITE : FILL;
    assign w_shd_cnt_nxt    = w_m_hs ? 3'd0 : w_merge_cnt;
    assign w_busy_ready_nxt = !w_shd_cnt_nxt[2];
`else
    assign w_act_load       = 1'b0;
    assign w_act_load_lanes = {WIN_W{1'b0}};
    assign w_act_load_idx   = 2'd0;
    assign w_out_nxt        = FILL;
    assign w_busy_ready_nxt = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_last_lane) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            WRITE: begin
                w_state_nxt = READ;
            end
            READ: begin
                if (r_rd_cnt == 3'd0) begin
                    w_state_nxt = OUT;
                end else begin
                    w_state_nxt = READ;
                end
            end
            OUT: begin
                if (w_m_hs) begin
                    w_state_nxt = w_out_nxt;
                end else begin
                    w_state_nxt = OUT;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // Input readiness for the coming cycle, derived from the next state.
    always_comb begin
        w_s_ready_nxt = 1'b0;
        if (w_state_nxt == FILL) begin
            w_s_ready_nxt = 1'b1;
        end else begin
            w_s_ready_nxt = w_busy_ready_nxt;
        end
    end

    // State register and strobes; strobes are decoded from the next state so
    // they line up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_s_ready   <= 1'b0;
            r_pim_write <= 1'b0;
            r_pim_read  <= 1'b0;
            r_m_valid   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_pim_write <= (w_state_nxt == WRITE);
            r_pim_read  <= (w_state_nxt == READ);
            r_m_valid   <= (w_state_nxt == OUT);
        end
    end

    // Read-cycle down-counter; zero marks the last read cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= 3'd0;
        end else if (r_state == WRITE) begin
            r_rd_cnt <= RD_INIT;
        end else if ((r_state == READ) && (r_rd_cnt != 3'd0)) begin
            r_rd_cnt <= r_rd_cnt - 3'd1;
        end else begin
            r_rd_cnt <= r_rd_cnt;
        end
    end

    // Result capture at the edge ending the last read cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data <= {OUT_W{1'b0}};
        end else if ((r_state == READ) && (r_rd_cnt == 3'd0)) begin
            r_m_data <= pim_data_out;
        end else begin
            r_m_data <= r_m_data;
        end
    end

    // Accepted-result counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_done <= 16'd0;
        end else if (w_m_hs) begin
            r_frames_done <= r_frames_done + 16'd1;
        end else begin
            r_frames_done <= r_frames_done;
        end
    end

    assign s_ready      = r_s_ready;
    assign pim_write    = r_pim_write;
    assign pim_read     = r_pim_read;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign frames_done  = r_frames_done;
    assign pim_data_in0 = w_act_lanes[DATA_W-1:0];
    assign pim_data_in1 = w_act_lanes[2*DATA_W-1:DATA_W];
    assign pim_data_in2 = w_act_lanes[3*DATA_W-1:2*DATA_W];
    assign pim_data_in3 = w_act_lanes[4*DATA_W-1:3*DATA_W];

endmodule
